// File: rtl/stopwatch_ctrl_if.sv
// Bundle between the key scanner / counter side and the stopwatch controller.
// master: the side that supplies key levels and live counter values.
// slave : the controller, which returns counter commands and display values.
interface stopwatch_ctrl_if;
  logic       key_ss;
  logic       key_clr;
  logic       key_lap;
  logic [5:0] cur_sec;
  logic [5:0] cur_min;
  logic       cnt_en;
  logic       cnt_clr;
  logic [5:0] disp_sec;
  logic [5:0] disp_min;
  logic       lap_frz;
  logic       ovf;
  logic [1:0] state;

  modport master (
    output key_ss, key_clr, key_lap, cur_sec, cur_min,
    input  cnt_en, cnt_clr, disp_sec, disp_min, lap_frz, ovf, state
  );

  modport slave (
    input  key_ss, key_clr, key_lap, cur_sec, cur_min,
    output cnt_en, cnt_clr, disp_sec, disp_min, lap_frz, ovf, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear/lap controller for an mm:ss stopwatch counter.
// Conditions raw key levels into single-cycle presses, divides clk down to a
// count-enable tick, drives counter enable/clear and holds a frozen lap value.
// Optional macro DEBOUNCE_EN: adds a DB_CYCLES stability filter after the
// 2-FF synchroniser on every key. Without it keys are only synchronised.
module stopwatch_ctrl #(
  parameter int unsigned PRESCALE  = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  localparam int                PW        = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(PRESCALE - 1);

  // Elaboration-time guard on parameter ranges.
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("stopwatch_ctrl: PRESCALE must be at least 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("stopwatch_ctrl: DB_CYCLES must be at least 1");
  end

  // Key vector order: bit 0 clr, bit 1 ss, bit 2 lap.
  logic [2:0] raw_keys;
  logic [2:0] lvl;
  logic [2:0] hist_q;
  logic [2:0] press;

  assign raw_keys = {bus.key_lap, bus.key_ss, bus.key_clr};

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchroniser for the asynchronous key level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= raw_keys[gi];
        sync2_q <= sync1_q;
      end
    end

`ifdef DEBOUNCE_EN
    localparam int            DBW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);
    logic [DBW-1:0] db_cnt_q;
    logic           db_q;

    // Accept a new level only after it has differed from the accepted one
    // for DB_CYCLES consecutive cycles; any shorter excursion restarts the count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt_q <= '0;
        db_q     <= 1'b0;
      end else if (sync2_q == db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_MAX) begin
        db_q     <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DBW'(1);
      end
    end

    assign lvl[gi] = db_q;
`else
    assign lvl[gi] = sync2_q;
`endif
  end

  // Previous conditioned level, for rising-edge (press) detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= '0;
    else     hist_q <= lvl;
  end

  assign press = lvl & ~hist_q;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic          cnt_en_q;
  logic          cnt_clr_q;
  logic          lap_frz_q;
  logic          ovf_q;
  logic [5:0]    lap_sec_q;
  logic [5:0]    lap_min_q;

  logic p_clr, p_ss, p_lap;
  logic counting;
  logic tick;
  logic at_max;

  assign p_clr    = press[0];
  assign p_ss     = press[1];
  assign p_lap    = press[2];
  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick     = counting && (presc_q == PRESC_MAX);
  assign at_max   = (bus.cur_sec == 6'd59) && (bus.cur_min == 6'd59);

  // Mode FSM with prescaler and registered outputs. An ss press that leaves
  // RUN/LAP holds the prescaler in that cycle, so a resumed run picks up the
  // exact phase it was paused at and no tick is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b1;
      lap_frz_q <= 1'b0;
      ovf_q     <= 1'b0;
      lap_sec_q <= '0;
      lap_min_q <= '0;
    end else begin
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (p_clr) begin
            cnt_clr_q <= 1'b1;
            presc_q   <= '0;
            ovf_q     <= 1'b0;
          end else if (p_ss) begin
            state_q <= S_RUN;
          end
        end
        S_PAUSE: begin
          if (p_clr) begin
            state_q   <= S_IDLE;
            cnt_clr_q <= 1'b1;
            presc_q   <= '0;
            ovf_q     <= 1'b0;
          end else if (p_ss && !ovf_q) begin
            state_q <= S_RUN;
          end
        end
        S_RUN, S_LAP: begin
          if (p_ss) begin
            state_q   <= S_PAUSE;
            lap_frz_q <= 1'b0;
          end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick && at_max) begin
              // Saturate at 59:59: swallow the tick and stop.
              state_q   <= S_PAUSE;
              ovf_q     <= 1'b1;
              lap_frz_q <= 1'b0;
            end else begin
              cnt_en_q <= tick;
              if (p_lap) begin
                if (state_q == S_RUN) begin
                  state_q   <= S_LAP;
                  lap_sec_q <= bus.cur_sec;
                  lap_min_q <= bus.cur_min;
                  lap_frz_q <= 1'b1;
                end else begin
                  state_q   <= S_RUN;
                  lap_frz_q <= 1'b0;
                end
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cnt_en   = cnt_en_q;
  assign bus.cnt_clr  = cnt_clr_q;
  assign bus.lap_frz  = lap_frz_q;
  assign bus.ovf      = ovf_q;
  assign bus.state    = state_q;
  assign bus.disp_sec = lap_frz_q ? lap_sec_q : bus.cur_sec;
  assign bus.disp_min = lap_frz_q ? lap_min_q : bus.cur_min;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with PRESCALE=4, DB_CYCLES=3.
module tb_stopwatch_ctrl;
  localparam int PRESCALE  = 4;
  localparam int DB_CYCLES = 3;
`ifdef DEBOUNCE_EN
  localparam int HOLD = DB_CYCLES + 1;
  localparam int LAT  = DB_CYCLES + 3;
  localparam int PRE  = DB_CYCLES + 3;
`else
  localparam int HOLD = 1;
  localparam int LAT  = 3;
  localparam int PRE  = 0;
`endif
  localparam int PRESS_CYC = PRE + LAT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  stopwatch_ctrl_if sw_if();

  stopwatch_ctrl #(.PRESCALE(PRESCALE), .DB_CYCLES(DB_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input logic s, input logic c, input logic l);
    sw_if.key_ss  = s;
    sw_if.key_clr = c;
    sw_if.key_lap = l;
  endtask

  // Returns 1ns after the edge at which the press takes effect.
  task automatic press(input logic s, input logic c, input logic l);
    repeat (PRE) cyc();
    set_keys(s, c, l);
    for (int i = 1; i <= LAT; i++) begin
      cyc();
      if (i == HOLD) set_keys(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_keys(1'b0, 1'b0, 1'b0);
    sw_if.cur_sec = 6'd0;
    sw_if.cur_min = 6'd0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    set_keys(1'b0, 1'b0, 1'b0);
    sw_if.cur_sec = 6'd34;
    sw_if.cur_min = 6'd12;
    cyc();
    tests++; if (sw_if.state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b want 00", sw_if.state); end
    tests++; if (sw_if.cnt_clr !== 1'b1) begin fails++; $display("FAIL reset_cnt_clr: got %b want 1", sw_if.cnt_clr); end
    tests++; if (sw_if.cnt_en !== 1'b0) begin fails++; $display("FAIL reset_cnt_en: got %b want 0", sw_if.cnt_en); end
    tests++; if (sw_if.lap_frz !== 1'b0 || sw_if.ovf !== 1'b0) begin fails++; $display("FAIL reset_frz_ovf: got %b%b want 00", sw_if.lap_frz, sw_if.ovf); end
    tests++; if (sw_if.disp_min !== 6'd12 || sw_if.disp_sec !== 6'd34) begin fails++; $display("FAIL reset_disp: got %0d:%0d want 12:34", sw_if.disp_min, sw_if.disp_sec); end
    rst = 1'b0;
    cyc();
    tests++; if (sw_if.cnt_clr !== 1'b0) begin fails++; $display("FAIL reset_release_clr: got %b want 0", sw_if.cnt_clr); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_idle_keys();
    do_reset();
    press(1'b0, 1'b0, 1'b1);
    tests++; if (sw_if.state !== 2'b00 || sw_if.lap_frz !== 1'b0) begin fails++; $display("FAIL idle_lap_ignored: got state %b frz %b want 00 0", sw_if.state, sw_if.lap_frz); end
    press(1'b0, 1'b1, 1'b0);
    tests++; if (sw_if.state !== 2'b00 || sw_if.cnt_clr !== 1'b1) begin fails++; $display("FAIL idle_clr: got state %b clr %b want 00 1", sw_if.state, sw_if.cnt_clr); end
    cyc();
    tests++; if (sw_if.cnt_clr !== 1'b0) begin fails++; $display("FAIL idle_clr_pulse: got %b want 0", sw_if.cnt_clr); end
    $display("[TB] test_idle_keys done");
  endtask

  task automatic test_run();
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    tests++; if (sw_if.state !== 2'b01) begin fails++; $display("FAIL run_enter: got %b want 01", sw_if.state); end
    for (int k = 1; k <= 20; k++) begin
      cyc();
      tests++;
      if (sw_if.cnt_en !== ((k % 4) == 0) || sw_if.cnt_clr !== 1'b0) begin
        fails++;
        $display("FAIL run_tick_c%0d: got en %b clr %b want en %b clr 0", k, sw_if.cnt_en, sw_if.cnt_clr, ((k % 4) == 0));
      end
    end
    tests++; if (sw_if.state !== 2'b01) begin fails++; $display("FAIL run_hold: got %b want 01", sw_if.state); end
    $display("[TB] test_run done");
  endtask

  task automatic test_pause_resume();
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    // Pause press lands on the edge where the held prescaler value is 2.
    repeat (19 - PRESS_CYC) cyc();
    press(1'b1, 1'b0, 1'b0);
    tests++; if (sw_if.state !== 2'b10) begin fails++; $display("FAIL pause_enter: got %b want 10", sw_if.state); end
    for (int k = 1; k <= 10; k++) begin
      cyc();
      tests++; if (sw_if.cnt_en !== 1'b0) begin fails++; $display("FAIL pause_no_tick_c%0d: got %b want 0", k, sw_if.cnt_en); end
    end
    press(1'b1, 1'b0, 1'b0);
    tests++; if (sw_if.state !== 2'b01) begin fails++; $display("FAIL resume_state: got %b want 01", sw_if.state); end
    cyc();
    tests++; if (sw_if.cnt_en !== 1'b0) begin fails++; $display("FAIL resume_c1: got %b want 0", sw_if.cnt_en); end
    cyc();
    tests++; if (sw_if.cnt_en !== 1'b1) begin fails++; $display("FAIL resume_c2: got %b want 1", sw_if.cnt_en); end
    $display("[TB] test_pause_resume done");
  endtask

  task automatic test_lap();
    int pulses;
    do_reset();
    sw_if.cur_min = 6'd3;
    sw_if.cur_sec = 6'd17;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    tests++; if (sw_if.state !== 2'b11 || sw_if.lap_frz !== 1'b1) begin fails++; $display("FAIL lap_enter: got state %b frz %b want 11 1", sw_if.state, sw_if.lap_frz); end
    sw_if.cur_sec = 6'd18;
    #1;
    tests++; if (sw_if.disp_min !== 6'd3 || sw_if.disp_sec !== 6'd17) begin fails++; $display("FAIL lap_frozen: got %0d:%0d want 3:17", sw_if.disp_min, sw_if.disp_sec); end
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (sw_if.cnt_en === 1'b1) pulses++;
    end
    tests++; if (pulses != 2) begin fails++; $display("FAIL lap_counting: got %0d pulses want 2", pulses); end
    press(1'b0, 1'b0, 1'b1);
    tests++; if (sw_if.state !== 2'b01 || sw_if.lap_frz !== 1'b0) begin fails++; $display("FAIL lap_release: got state %b frz %b want 01 0", sw_if.state, sw_if.lap_frz); end
    sw_if.cur_min = 6'd4;
    sw_if.cur_sec = 6'd2;
    #1;
    tests++; if (sw_if.disp_min !== 6'd4 || sw_if.disp_sec !== 6'd2) begin fails++; $display("FAIL lap_live: got %0d:%0d want 4:2", sw_if.disp_min, sw_if.disp_sec); end
    $display("[TB] test_lap done");
  endtask

  task automatic test_saturation();
    do_reset();
    sw_if.cur_min = 6'd59;
    sw_if.cur_sec = 6'd59;
    press(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      tests++; if (sw_if.state !== 2'b01 || sw_if.cnt_en !== 1'b0) begin fails++; $display("FAIL sat_pre_c%0d: got state %b en %b want 01 0", k, sw_if.state, sw_if.cnt_en); end
    end
    cyc();
    tests++; if (sw_if.cnt_en !== 1'b0) begin fails++; $display("FAIL sat_en: got %b want 0", sw_if.cnt_en); end
    tests++; if (sw_if.state !== 2'b10 || sw_if.ovf !== 1'b1) begin fails++; $display("FAIL sat_state: got state %b ovf %b want 10 1", sw_if.state, sw_if.ovf); end
    press(1'b1, 1'b0, 1'b0);
    tests++; if (sw_if.state !== 2'b10 || sw_if.ovf !== 1'b1) begin fails++; $display("FAIL sat_ss_ignored: got state %b ovf %b want 10 1", sw_if.state, sw_if.ovf); end
    press(1'b0, 1'b1, 1'b0);
    tests++; if (sw_if.state !== 2'b00 || sw_if.cnt_clr !== 1'b1 || sw_if.ovf !== 1'b0) begin fails++; $display("FAIL sat_clr: got state %b clr %b ovf %b want 00 1 0", sw_if.state, sw_if.cnt_clr, sw_if.ovf); end
    cyc();
    tests++; if (sw_if.cnt_clr !== 1'b0) begin fails++; $display("FAIL sat_clr_pulse: got %b want 0", sw_if.cnt_clr); end
    $display("[TB] test_saturation done");
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    tests++; if (sw_if.state !== 2'b10 || sw_if.cnt_clr !== 1'b0) begin fails++; $display("FAIL simul_run: got state %b clr %b want 10 0", sw_if.state, sw_if.cnt_clr); end
    press(1'b1, 1'b1, 1'b0);
    tests++; if (sw_if.state !== 2'b00 || sw_if.cnt_clr !== 1'b1) begin fails++; $display("FAIL simul_pause: got state %b clr %b want 00 1", sw_if.state, sw_if.cnt_clr); end
    $display("[TB] test_simultaneous done");
  endtask

  task automatic test_async_reset();
    bit seen;
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (sw_if.cnt_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    tests++; if (!seen) begin fails++; $display("FAIL arst_find_tick: got no cnt_en within 8 cycles want one"); end
    rst = 1'b1;
    #2;
    tests++; if (sw_if.state !== 2'b00 || sw_if.cnt_en !== 1'b0) begin fails++; $display("FAIL arst_state: got state %b en %b want 00 0", sw_if.state, sw_if.cnt_en); end
    tests++; if (sw_if.cnt_clr !== 1'b1 || sw_if.lap_frz !== 1'b0) begin fails++; $display("FAIL arst_clr_frz: got clr %b frz %b want 1 0", sw_if.cnt_clr, sw_if.lap_frz); end
    cyc();
    tests++; if (sw_if.cnt_clr !== 1'b1) begin fails++; $display("FAIL arst_hold_clr: got %b want 1", sw_if.cnt_clr); end
    rst = 1'b0;
    cyc();
    tests++; if (sw_if.cnt_clr !== 1'b0 || sw_if.state !== 2'b00) begin fails++; $display("FAIL arst_release: got clr %b state %b want 0 00", sw_if.cnt_clr, sw_if.state); end
    $display("[TB] test_async_reset done");
  endtask

`ifdef DEBOUNCE_EN
  task automatic test_glitch();
    do_reset();
    sw_if.key_ss = 1'b1;
    cyc();
    cyc();
    sw_if.key_ss = 1'b0;
    repeat (12) cyc();
    tests++; if (sw_if.state !== 2'b00) begin fails++; $display("FAIL glitch: got %b want 00", sw_if.state); end
    $display("[TB] test_glitch done");
  endtask
`endif

  initial begin
    test_reset();
    test_idle_keys();
    test_run();
    test_pause_resume();
    test_lap();
    test_saturation();
    test_simultaneous();
    test_async_reset();
`ifdef DEBOUNCE_EN
    test_glitch();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
